// File: rtl/ahb_req_manager_pkg.sv
// Shared configuration type, AHB-Lite encodings and request legality helpers
// used by the AHB request manager and its interface.
package ahb_req_manager_pkg;

    typedef struct packed {
        int PA_BITS;
        int AHBW;
        int XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{PA_BITS: 32, AHBW: 32, XLEN: 32};

    localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] AHB_HBURST_SINGLE = 3'b000;
    localparam logic [3:0] AHB_HPROT_DEFAULT = 4'b0011;

    // A transfer may not be wider than the data bus and must be naturally aligned.
    function automatic logic req_legal(input logic [2:0] size, input logic [63:0] adr,
                                       input int ahbw);
        logic [63:0] mask;
        mask = (64'd1 << size) - 64'd1;
        return (int'(size) <= $clog2(ahbw / 8)) && ((adr & mask) == 64'd0);
    endfunction

endpackage

// File: rtl/ahb_req_manager_if.sv
// Request/response stream plus AHB-Lite manager bus signals; the master modport
// is the manager side, the slave modport is the requester/subordinate side.
interface ahb_req_manager_if
    import ahb_req_manager_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
) ();

    logic                    ReqValid;
    logic                    ReqReady;
    logic [P.PA_BITS-1:0]    ReqAdr;
    logic                    ReqWrite;
    logic [2:0]              ReqSize;
    logic [P.AHBW-1:0]       ReqWData;
    logic [P.AHBW/8-1:0]     ReqStrb;

    logic                    RspValid;
    logic [P.AHBW-1:0]       RspRData;
    logic                    RspErr;

    logic [P.PA_BITS-1:0]    HADDR;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [2:0]              HBURST;
    logic [3:0]              HPROT;
    logic [1:0]              HTRANS;
    logic                    HMASTLOCK;
    logic [P.AHBW-1:0]       HWDATA;
    logic [P.AHBW/8-1:0]     HWSTRB;
    logic [P.AHBW-1:0]       HRDATA;
    logic                    HREADY;
    logic                    HRESP;

    modport master (
        input  ReqValid, ReqAdr, ReqWrite, ReqSize, ReqWData, ReqStrb,
        input  HRDATA, HREADY, HRESP,
        output ReqReady, RspValid, RspRData, RspErr,
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA, HWSTRB
    );

    modport slave (
        output ReqValid, ReqAdr, ReqWrite, ReqSize, ReqWData, ReqStrb,
        output HRDATA, HREADY, HRESP,
        input  ReqReady, RspValid, RspRData, RspErr,
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA, HWSTRB
    );

endinterface

// File: rtl/ahb_req_manager.sv
// AHB-Lite manager: converts a valid/ready single-beat request stream into pipelined
// SINGLE transfers with one address phase and one data phase overlapped.
module ahb_req_manager
    import ahb_req_manager_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_req_manager_if.master bus
);

    localparam int AW = P.PA_BITS;
    localparam int DW = P.AHBW;
    localparam int SW = P.AHBW / 8;

    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic          a_write;
    logic [2:0]    a_size;
    logic [DW-1:0] a_wdata;
    logic [SW-1:0] a_strb;

    logic          d_valid;
    logic          d_write;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_strb;

    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic          a_load;
    logic          accept;
    logic          d_done;

    // An empty address stage may be refilled even during a wait state: the bus is idle.
    assign a_load = ~a_valid | bus.HREADY;
    assign accept = HRESETn & a_load & bus.ReqValid;
    assign d_done = bus.HREADY & d_valid;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            a_valid <= 1'b0;
            a_addr  <= '0;
            a_write <= 1'b0;
            a_size  <= '0;
            a_wdata <= '0;
            a_strb  <= '0;
        end else if (a_load) begin
            a_valid <= accept;
            a_addr  <= accept ? bus.ReqAdr   : '0;
            a_write <= accept ? bus.ReqWrite : 1'b0;
            a_size  <= accept ? bus.ReqSize  : '0;
            a_wdata <= accept ? bus.ReqWData : '0;
            a_strb  <= accept ? bus.ReqStrb  : '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_wdata <= '0;
            d_strb  <= '0;
        end else if (bus.HREADY) begin
            d_valid <= a_valid;
            d_write <= a_write;
            d_wdata <= a_wdata;
            d_strb  <= a_strb;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= d_done;
            rsp_rdata <= (d_done && !d_write) ? bus.HRDATA : '0;
            rsp_err   <= d_done & bus.HRESP;
        end
    end

    assign bus.ReqReady  = HRESETn & a_load;
    assign bus.RspValid  = rsp_valid;
    assign bus.RspRData  = rsp_rdata;
    assign bus.RspErr    = rsp_err;

    assign bus.HTRANS    = a_valid ? AHB_HTRANS_NONSEQ : AHB_HTRANS_IDLE;
    assign bus.HADDR     = a_addr;
    assign bus.HWRITE    = a_write;
    assign bus.HSIZE     = a_size;
    assign bus.HBURST    = AHB_HBURST_SINGLE;
    assign bus.HPROT     = AHB_HPROT_DEFAULT;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = (d_valid && d_write) ? d_wdata : '0;
    assign bus.HWSTRB    = (d_valid && d_write) ? d_strb  : '0;

    // Oversized or misaligned requests are still forwarded; this only flags them.
    req_legal_check: assert property (@(posedge HCLK) disable iff (!HRESETn)
        accept |-> req_legal(bus.ReqSize, 64'(bus.ReqAdr), DW));

endmodule

// File: tb/tb_ahb_req_manager.sv
// Directed self-checking bench for ahb_req_manager: latency, back-to-back reads,
// wait states, error responses, mid-transfer reset and acceptance while stalled.
module tb_ahb_req_manager;
    import ahb_req_manager_pkg::*;

    localparam cvw_t CFG = '{PA_BITS: 32, AHBW: 32, XLEN: 32};

    logic HCLK;
    logic HRESETn;
    int   testsRun;
    int   failCount;

    ahb_req_manager_if #(.P(CFG)) bus ();

    ahb_req_manager #(.P(CFG)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.master)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] adr,
                                 input logic [31:0] wdata, input logic [3:0] strb);
        bus.ReqValid = valid;
        bus.ReqWrite = write;
        bus.ReqAdr   = adr;
        bus.ReqSize  = 3'd2;
        bus.ReqWData = wdata;
        bus.ReqStrb  = strb;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        HRESETn     = 1'b0;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 1'b0;
        bus.HRDATA  = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();

        // Reset state
        checkOutput("rst_htrans",   64'(bus.HTRANS),   64'h0);
        checkOutput("rst_haddr",    64'(bus.HADDR),    64'h0);
        checkOutput("rst_rspvalid", 64'(bus.RspValid), 64'h0);
        checkOutput("rst_hwdata",   64'(bus.HWDATA),   64'h0);
        checkOutput("rst_reqready", 64'(bus.ReqReady), 64'h0);
        checkOutput("rst_hburst",   64'(bus.HBURST),   64'h0);
        checkOutput("rst_hprot",    64'(bus.HPROT),    64'h3);
        HRESETn = 1'b1;
        tick();

        // 1: single write, zero wait states
        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
        checkOutput("t1_reqready", 64'(bus.ReqReady), 64'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t1_htrans",  64'(bus.HTRANS), 64'h2);
        checkOutput("t1_haddr",   64'(bus.HADDR),  64'h8000_0000);
        checkOutput("t1_hwrite",  64'(bus.HWRITE), 64'h1);
        checkOutput("t1_hwdata_early", 64'(bus.HWDATA), 64'h0);
        tick();
        bus.HRDATA = 32'hFFFF_FFFF;
        checkOutput("t1_hwdata",  64'(bus.HWDATA), 64'hDEAD_BEEF);
        checkOutput("t1_hwstrb",  64'(bus.HWSTRB), 64'hF);
        checkOutput("t1_idle",    64'(bus.HTRANS), 64'h0);
        checkOutput("t1_rsp_early", 64'(bus.RspValid), 64'h0);
        tick();
        bus.HRDATA = '0;
        checkOutput("t1_rspvalid", 64'(bus.RspValid), 64'h1);
        checkOutput("t1_rsperr",   64'(bus.RspErr),   64'h0);
        checkOutput("t1_rsprdata", 64'(bus.RspRData), 64'h0);
        tick();
        checkOutput("t1_rsp_done", 64'(bus.RspValid), 64'h0);

        // 2: three back-to-back reads
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        checkOutput("t2_nonseq0", 64'(bus.HTRANS), 64'h2);
        checkOutput("t2_haddr0",  64'(bus.HADDR),  64'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        bus.HRDATA = 32'h11;
        checkOutput("t2_nonseq1", 64'(bus.HTRANS), 64'h2);
        checkOutput("t2_haddr1",  64'(bus.HADDR),  64'h8);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.HRDATA = 32'h22;
        checkOutput("t2_nonseq2", 64'(bus.HTRANS), 64'h2);
        checkOutput("t2_haddr2",  64'(bus.HADDR),  64'h10);
        checkOutput("t2_rsp0v",   64'(bus.RspValid), 64'h1);
        checkOutput("t2_rsp0d",   64'(bus.RspRData), 64'h11);
        tick();
        bus.HRDATA = 32'h33;
        checkOutput("t2_idle",    64'(bus.HTRANS),   64'h0);
        checkOutput("t2_rsp1v",   64'(bus.RspValid), 64'h1);
        checkOutput("t2_rsp1d",   64'(bus.RspRData), 64'h22);
        tick();
        bus.HRDATA = '0;
        checkOutput("t2_rsp2v",   64'(bus.RspValid), 64'h1);
        checkOutput("t2_rsp2d",   64'(bus.RspRData), 64'h33);
        tick();
        checkOutput("t2_rsp_done", 64'(bus.RspValid), 64'h0);

        // 3: read then write, two wait states in the read's data phase
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 4'h3);
        checkOutput("t3_reqready_a", 64'(bus.ReqReady), 64'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.HREADY = 1'b0;
        #1;
        checkOutput("t3_reqready_stall", 64'(bus.ReqReady), 64'h0);
        checkOutput("t3_haddr_w",   64'(bus.HADDR),  64'h44);
        checkOutput("t3_htrans_w",  64'(bus.HTRANS), 64'h2);
        checkOutput("t3_hwdata_rd", 64'(bus.HWDATA), 64'h0);
        tick();
        checkOutput("t3_rsp_stall", 64'(bus.RspValid), 64'h0);
        checkOutput("t3_haddr_hold", 64'(bus.HADDR),  64'h44);
        checkOutput("t3_htrans_hold", 64'(bus.HTRANS), 64'h2);
        tick();
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h55;
        checkOutput("t3_rsp_stall2", 64'(bus.RspValid), 64'h0);
        checkOutput("t3_haddr_hold2", 64'(bus.HADDR), 64'h44);
        tick();
        bus.HRDATA = '0;
        checkOutput("t3_rsprd_v", 64'(bus.RspValid), 64'h1);
        checkOutput("t3_rsprd_d", 64'(bus.RspRData), 64'h55);
        checkOutput("t3_hwdata",  64'(bus.HWDATA),   64'hCAFE_F00D);
        checkOutput("t3_hwstrb",  64'(bus.HWSTRB),   64'h3);
        tick();
        checkOutput("t3_rspwr_v", 64'(bus.RspValid), 64'h1);
        checkOutput("t3_rspwr_d", 64'(bus.RspRData), 64'h0);
        tick();
        checkOutput("t3_rsp_done", 64'(bus.RspValid), 64'h0);

        // 4: error response on a write with a read queued behind it
        applyStimulus(1'b1, 1'b1, 32'h1000, 32'h1234_5678, 4'hF);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.HRESP  = 1'b1;
        bus.HREADY = 1'b0;
        checkOutput("t4_hwdata", 64'(bus.HWDATA), 64'h1234_5678);
        checkOutput("t4_haddr",  64'(bus.HADDR),  64'h2000);
        tick();
        bus.HREADY = 1'b1;
        checkOutput("t4_rsp_err1", 64'(bus.RspValid), 64'h0);
        checkOutput("t4_haddr_hold", 64'(bus.HADDR), 64'h2000);
        tick();
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h77;
        checkOutput("t4_err_v",  64'(bus.RspValid), 64'h1);
        checkOutput("t4_err",    64'(bus.RspErr),   64'h1);
        tick();
        bus.HRDATA = '0;
        checkOutput("t4_rd_v",   64'(bus.RspValid), 64'h1);
        checkOutput("t4_rd_err", 64'(bus.RspErr),   64'h0);
        checkOutput("t4_rd_d",   64'(bus.RspRData), 64'h77);
        tick();
        checkOutput("t4_rsp_done", 64'(bus.RspValid), 64'h0);

        // 5: reset during a stalled data phase
        applyStimulus(1'b1, 1'b1, 32'h300, 32'hA5A5_A5A5, 4'hF);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h304, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.HREADY = 1'b0;
        checkOutput("t5_hwdata", 64'(bus.HWDATA), 64'hA5A5_A5A5);
        tick();
        HRESETn = 1'b0;
        #1;
        checkOutput("t5_reqready_rst", 64'(bus.ReqReady), 64'h0);
        tick();
        HRESETn    = 1'b1;
        bus.HREADY = 1'b1;
        checkOutput("t5_htrans",   64'(bus.HTRANS),   64'h0);
        checkOutput("t5_haddr",    64'(bus.HADDR),    64'h0);
        checkOutput("t5_hwrite",   64'(bus.HWRITE),   64'h0);
        checkOutput("t5_hwdata0",  64'(bus.HWDATA),   64'h0);
        checkOutput("t5_hwstrb0",  64'(bus.HWSTRB),   64'h0);
        checkOutput("t5_rspvalid", 64'(bus.RspValid), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t5_no_rsp", 64'(bus.RspValid), 64'h0);
        end

        // 6: request accepted while HREADY=0 and the bus is idle
        bus.HREADY = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        checkOutput("t6_reqready", 64'(bus.ReqReady), 64'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t6_htrans",   64'(bus.HTRANS),   64'h2);
        checkOutput("t6_haddr",    64'(bus.HADDR),    64'h500);
        checkOutput("t6_reqready_busy", 64'(bus.ReqReady), 64'h0);
        tick();
        checkOutput("t6_htrans_hold", 64'(bus.HTRANS), 64'h2);
        checkOutput("t6_haddr_hold",  64'(bus.HADDR),  64'h500);
        bus.HREADY = 1'b1;
        tick();
        bus.HRDATA = 32'h99;
        checkOutput("t6_idle", 64'(bus.HTRANS), 64'h0);
        tick();
        bus.HRDATA = '0;
        checkOutput("t6_rsp_v", 64'(bus.RspValid), 64'h1);
        checkOutput("t6_rsp_d", 64'(bus.RspRData), 64'h99);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
